// File: rtl/geofence_driver_if.sv
// rtl/geofence_driver_if.sv - X/Y stream and verdict link between geofence_driver and the engine
interface geofence_driver_if;
    logic       gf_reset;
    logic [9:0] X;
    logic [9:0] Y;
    logic       valid;
    logic       is_inside;

    // Driver side: owns the engine reset and the coordinate stream.
    modport master (
        output gf_reset,
        output X,
        output Y,
        input  valid,
        input  is_inside
    );

    // Engine side: consumes the stream and returns the verdict.
    modport slave (
        input  gf_reset,
        input  X,
        input  Y,
        output valid,
        output is_inside
    );
endinterface

// File: rtl/geofence_driver.sv
// rtl/geofence_driver.sv - frame sequencer for the geofence engine; GEOFENCE_DRIVER_SCORE_EN adds frame_cnt/inside_cnt
module geofence_driver #(
    parameter int FENCE_PTS   = 6,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic        start,
    output logic        busy,
    output logic        result_valid,
    output logic        result_inside,
    output logic        timeout,
    geofence_driver_if.master eng
`ifdef GEOFENCE_DRIVER_SCORE_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] inside_cnt
`endif
);

    localparam int IDX_W = $clog2(FENCE_PTS + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FENCE_PTS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_OBJ,
        SEND_PTS,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [CNT_W-1:0] wait_cnt;

    // Entry 0 is the object point, entries 1..FENCE_PTS are the fence vertices.
    logic [9:0] buf_x [0:FENCE_PTS];
    logic [9:0] buf_y [0:FENCE_PTS];

    assign nxt_idx = idx + 1'b1;

    // Frame buffer: host writes land in any state; out-of-range entries are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) <= FENCE_PTS)) begin
            buf_x[wr_addr] <= wr_x;
            buf_y[wr_addr] <= wr_y;
        end
    end

    // Sequencer: release engine, stream object then vertices, wait for verdict or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            eng.gf_reset  <= 1'b1;
            eng.X         <= '0;
            eng.Y         <= '0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            result_inside <= 1'b0;
            timeout       <= 1'b0;
            idx           <= '0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= SEND_OBJ;
                        busy         <= 1'b1;
                        eng.gf_reset <= 1'b0;
                        eng.X        <= buf_x[0];
                        eng.Y        <= buf_y[0];
                        idx          <= '0;
                        wait_cnt     <= '0;
                    end
                end
                SEND_OBJ: begin
                    eng.X <= buf_x[1];
                    eng.Y <= buf_y[1];
                    idx   <= IDX_W'(1);
                    state <= SEND_PTS;
                end
                SEND_PTS: begin
                    // The last vertex stays on X/Y for the whole wait.
                    if (idx == LAST_IDX) begin
                        state <= WAIT;
                    end else begin
                        idx   <= nxt_idx;
                        eng.X <= buf_x[nxt_idx];
                        eng.Y <= buf_y[nxt_idx];
                    end
                end
                WAIT: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    // A verdict arriving on the expiry cycle still wins over the timeout.
                    if (eng.valid) begin
                        result_inside <= eng.is_inside;
                        timeout       <= 1'b0;
                        result_valid  <= 1'b1;
                        state         <= DONE;
                    end else if (wait_cnt == TO_LAST) begin
                        result_inside <= 1'b0;
                        timeout       <= 1'b1;
                        result_valid  <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
                    timeout      <= 1'b0;
                    eng.gf_reset <= 1'b1;
                    eng.X        <= '0;
                    eng.Y        <= '0;
                    busy         <= 1'b0;
                    idx          <= '0;
                    wait_cnt     <= '0;
                    state        <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    eng.gf_reset <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

`ifdef GEOFENCE_DRIVER_SCORE_EN
    // Result tallies, counted on each result pulse and saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt  <= '0;
            inside_cnt <= '0;
        end else if (result_valid) begin
            if (frame_cnt != 16'hFFFF) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (result_inside && (inside_cnt != 16'hFFFF)) begin
                inside_cnt <= inside_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_geofence_driver.sv
// tb/tb_geofence_driver.sv - directed self-checking bench for geofence_driver
module tb_geofence_driver;

    localparam int FENCE_PTS   = 6;
    localparam int TIMEOUT_CYC = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic       start;
    logic       busy;
    logic       result_valid;
    logic       result_inside;
    logic       timeout;
`ifdef GEOFENCE_DRIVER_SCORE_EN
    logic [15:0] frame_cnt;
    logic [15:0] inside_cnt;
`endif

    geofence_driver_if eng ();

    geofence_driver #(
        .FENCE_PTS   (FENCE_PTS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_x          (wr_x),
        .wr_y          (wr_y),
        .start         (start),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_inside (result_inside),
        .timeout       (timeout),
        .eng           (eng)
`ifdef GEOFENCE_DRIVER_SCORE_EN
        ,
        .frame_cnt     (frame_cnt),
        .inside_cnt    (inside_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rv_count = 0;
    int bx [0:FENCE_PTS];
    int by [0:FENCE_PTS];

    always @(negedge clk) begin
        if (result_valid) rv_count++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int x, input int y);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_x    = 10'(x);
        wr_y    = 10'(y);
        if (a <= FENCE_PTS) begin
            bx[a] = x;
            by[a] = y;
        end
        tick();
        wr_en = 1'b0;
    endtask

    // One full frame. noise: start and an opposite valid during SEND_PTS, plus a
    // write to a not-yet-presented vertex that must land in this frame.
    task automatic do_frame(input string tag, input bit give_valid, input bit ins, input bit noise);
        int rv0;
        int early;
        rv0   = rv_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_gf_reset_low"}, int'(eng.gf_reset), 0);
        check({tag, "_busy_high"}, int'(busy), 1);
        check({tag, "_obj_x"}, int'(eng.X), bx[0]);
        check({tag, "_obj_y"}, int'(eng.Y), by[0]);
        for (int k = 1; k <= FENCE_PTS; k++) begin
            if (noise && k == 2) begin
                start = 1'b1;
                eng.valid = 1'b1;
                eng.is_inside = ~ins;
            end
            if (noise && k == 3) begin
                wr_en   = 1'b1;
                wr_addr = 3'd5;
                wr_x    = 10'd333;
                wr_y    = 10'd444;
                bx[5]   = 333;
                by[5]   = 444;
            end
            tick();
            start = 1'b0;
            eng.valid = 1'b0;
            wr_en = 1'b0;
            check({tag, "_vx"}, int'(eng.X), bx[k]);
            check({tag, "_vy"}, int'(eng.Y), by[k]);
        end
        tick();
        check({tag, "_hold_x"}, int'(eng.X), bx[FENCE_PTS]);
        check({tag, "_rv_early"}, int'(result_valid), 0);
        if (give_valid) begin
            eng.valid = 1'b1;
            eng.is_inside = ins;
            tick();
            eng.valid = 1'b0;
            check({tag, "_rv"}, int'(result_valid), 1);
            check({tag, "_inside"}, int'(result_inside), int'(ins));
            check({tag, "_timeout"}, int'(timeout), 0);
        end else begin
            early = 0;
            for (int i = 1; i < TIMEOUT_CYC; i++) begin
                tick();
                if (result_valid) early++;
            end
            check({tag, "_no_early_rv"}, early, 0);
            tick();
            check({tag, "_to_rv"}, int'(result_valid), 1);
            check({tag, "_to_flag"}, int'(timeout), 1);
            check({tag, "_to_inside"}, int'(result_inside), 0);
        end
        tick();
        check({tag, "_rv_drop"}, int'(result_valid), 0);
        check({tag, "_gf_reset_back"}, int'(eng.gf_reset), 1);
        check({tag, "_busy_low"}, int'(busy), 0);
        check({tag, "_idle_x"}, int'(eng.X), 0);
        check({tag, "_one_result"}, rv_count - rv0, 1);
    endtask

    initial begin
        int rv0;
        reset_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_x = '0;
        wr_y = '0;
        start = 1'b0;
        eng.valid = 1'b0;
        eng.is_inside = 1'b0;
        tick();
        tick();
        check("rst_gf_reset", int'(eng.gf_reset), 1);
        check("rst_x", int'(eng.X), 0);
        check("rst_y", int'(eng.Y), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rv", int'(result_valid), 0);
        check("rst_inside", int'(result_inside), 0);
        check("rst_timeout", int'(timeout), 0);
        reset_n = 1'b1;
        tick();

        wr(0, 50, 50);
        wr(1, 100, 50);
        wr(2, 75, 93);
        wr(3, 25, 93);
        wr(4, 0, 50);
        wr(5, 25, 7);
        wr(6, 75, 7);
        wr(7, 999, 999);

        do_frame("in", 1'b1, 1'b1, 1'b0);
        do_frame("tmo", 1'b0, 1'b0, 1'b0);
        wr(0, 900, 900);
        do_frame("out", 1'b1, 1'b0, 1'b0);
        wr(0, 50, 50);
        do_frame("noise", 1'b1, 1'b1, 1'b1);

        // Reset in the middle of SEND_PTS.
        rv0 = rv_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_gf_reset", int'(eng.gf_reset), 1);
        check("mid_x", int'(eng.X), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_rv", int'(result_valid), 0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("mid_no_result", rv_count - rv0, 0);
        check("mid_idle_busy", int'(busy), 0);
        do_frame("fresh", 1'b1, 1'b0, 1'b0);

`ifdef GEOFENCE_DRIVER_SCORE_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("score_rst_frames", int'(frame_cnt), 0);
        do_frame("s1", 1'b1, 1'b1, 1'b0);
        do_frame("s2", 1'b1, 1'b0, 1'b0);
        do_frame("s3", 1'b1, 1'b1, 1'b0);
        check("score_frames", int'(frame_cnt), 3);
        check("score_inside", int'(inside_cnt), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/geofence_driver.md
# geofence_driver

Frame sequencer that feeds the geofence point-in-polygon engine on its X/Y stream and collects its verdict. A host loads one object point plus FENCE_PTS fence vertices into a local frame buffer, then pulses `start`. The block holds the engine in reset, releases it aligned to the frame, presents the points on consecutive cycles and waits for `valid`. It then returns `is_inside` to the host, with a timeout guard.

## Interface
- FENCE_PTS, 6, fence vertices per frame (buffer depth FENCE_PTS+1, entry 0 = object)
- TIMEOUT_CYC, 64, max cycles in WAIT before abort
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  frame buffer write strobe
- wr_addr  in  3  entry index: 0 = object, 1..FENCE_PTS = vertices
- wr_x, wr_y  in  10 each  coordinate written
- start  in  1  single-cycle launch request
- busy  out  1  high from accepted start until return to IDLE
- gf_reset  out  1  active-high reset to engine
- X, Y  out  10 each  coordinate stream to engine, registered
- valid  in  1  engine result strobe
- is_inside  in  1  engine verdict, qualified by valid
- result_valid  out  1  one-cycle pulse, verdict or timeout
- result_inside  out  1  captured verdict, held until next result
- timeout  out  1  high with result_valid when WAIT expired

## Operation
- FSM states: IDLE, SEND_OBJ, SEND_PTS, WAIT, DONE.
- IDLE:
  - gf_reset=1 and X/Y=0.
  - `start` moves to SEND_OBJ; on the same edge gf_reset←0 and X/Y←entry 0.
- SEND_OBJ: one cycle; next edge X/Y←entry 1, idx←1, go SEND_PTS.
- SEND_PTS:
  - Each edge idx increments and X/Y←entry idx.
  - Entry FENCE_PTS is presented one cycle, then the state is WAIT.
  - X/Y hold the last vertex through WAIT.
- WAIT: wait_cnt increments every cycle.
  - `valid`=1 → result_inside←is_inside, timeout←0, go DONE.
  - Otherwise wait_cnt==TIMEOUT_CYC-1 → result_inside←0, timeout←1, go DONE.
- DONE: result_valid=1 for this cycle, gf_reset←1, go IDLE.
- `valid` outside WAIT is ignored.
- `start` while busy is ignored. There is no queueing.
- `wr_en` is accepted in every state, so a frame may be preloaded during WAIT.
  - A write to entry k while SEND_* is presenting entry k or later does not affect the current frame.
  - A write to a not-yet-presented entry does affect the current frame. Hosts must not do this; the bench checks the write lands.
- wr_addr > FENCE_PTS: write dropped.
- Coordinates pass through unmodified (unsigned 10-bit). wait_cnt is sized ceil(log2(TIMEOUT_CYC+1)) and saturates.

## Timing
- Reset (reset_n=0), asynchronously:
  - state=IDLE, gf_reset=1, X=Y=0, busy=0, result_valid=0, result_inside=0, timeout=0, idx=0, wait_cnt=0.
  - Buffer contents are not reset.
- Start sampled at edge t:
  - Cycle t..t+1: gf_reset=0, X/Y=object.
  - Cycles t+1..t+FENCE_PTS: vertices 1..FENCE_PTS.
  - The engine samples the object at edge t+1 and vertices from edge t+2.
- busy rises at edge t and falls at the edge leaving DONE.
- Verdict latency: `valid` seen at edge v → result_valid high in cycle v..v+1 → busy low from edge v+1.
- Minimum start-to-start spacing: FENCE_PTS+4 cycles.
- Reset mid-frame: immediate return to IDLE with gf_reset=1. No result_valid is generated for the aborted frame.
- `valid` and timeout on the same edge: valid wins and timeout=0.

## Configuration
- GEOFENCE_DRIVER_SCORE_EN defined:
  - Adds outputs frame_cnt[15:0] and inside_cnt[15:0].
  - frame_cnt increments on every result_valid.
  - inside_cnt increments on result_valid with result_inside=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent and all other behaviour is identical.

## Test plan
- Load object (50,50) and a hexagon around it; start; engine model asserts valid,is_inside=1 → exactly one result_valid with result_inside=1, timeout=0, and X/Y sequence object then 6 vertices on consecutive cycles from edge t.
- Object (900,900) outside the same hexagon, engine verdict 0 → result_inside=0; gf_reset returns to 1 in the cycle after result_valid.
- Engine never asserts valid → result_valid and timeout high exactly TIMEOUT_CYC cycles after entering WAIT; result_inside=0.
- Pulse start while busy, and assert valid during SEND_PTS → both ignored; the frame completes normally with a single result.
- Deassert reset_n during SEND_PTS → all outputs immediately at reset values, no result_valid; a fresh start afterwards works.
- With GEOFENCE_DRIVER_SCORE_EN: 3 frames with verdicts 1,0,1 → frame_cnt=3, inside_cnt=2.
